// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM state
// encoding and parity mode selectors.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts oversample ticks while enabled and flags the
// tick that completes one bit period. The counter returns to zero only
// through the clear input or by completing a bit period.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic tick_i,
  input  logic en_i,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int TCW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);

  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;

  assign bit_end_o = en_i && tick_i && (tick_cnt_q == TICK_LAST);

  // Next tick count: clear wins, idle cycles hold, final tick restarts the period.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (clr_i) begin
      tick_cnt_d = '0;
    end else if (en_i && tick_i) begin
      tick_cnt_d = bit_end_o ? '0 : tick_cnt_q + TCW'(1);
    end
  end

  // Tick counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) tick_cnt_q <= '0;
    else          tick_cnt_q <= tick_cnt_d;
  end

endmodule

// File: rtl/uart_transmitter_cfg.sv
// Configurable UART transmitter: start bit, LSB-first data, optional
// parity, one or two stop bits, all timed from an oversample tick strobe.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | line high, tx_ready=1, waiting for tx_valid
// ST_START  | driving start bit (0)
// ST_DATA   | shifting latched word out, LSB first
// ST_PARITY | driving parity bit (skipped when parity is off)
// ST_STOP   | driving stop bit(s) (1), then back to idle
module uart_transmitter_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 system_clk,
  input  logic                 rst_n,
  input  logic                 tick_in,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_data
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_transmitter_cfg: DATA_BITS must be 5..9");
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE > 64) begin : g_bad_oversample
    $error("uart_transmitter_cfg: OVERSAMPLE must be 4..64");
  end
  if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_EVEN &&
      PARITY_MODE != PARITY_ODD) begin : g_bad_parity
    $error("uart_transmitter_cfg: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_transmitter_cfg: STOP_BITS must be 1 or 2");
  end

  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_data_q, tx_data_d;
  logic                 tx_done_q, tx_done_d;
  logic                 timer_clr;
  logic                 bit_end;

  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = (state_q != ST_IDLE);
  assign tx_done  = tx_done_q;
  assign tx_data  = tx_data_q;

  // Enabled only outside idle so stray ticks before acceptance are ignored.
  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk_i    (system_clk),
    .rst_n_i  (rst_n),
    .tick_i   (tick_in),
    .en_i     (tx_busy),
    .clr_i    (timer_clr),
    .bit_end_o(bit_end)
  );

  // Frame sequencing; tx_data_d is set on the edge that ends each bit so the
  // line register changes exactly at bit boundaries.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_data_d = tx_data_q;
    tx_done_d = 1'b0;
    timer_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d   = ST_START;
          shift_d   = data_in;
          parity_d  = (PARITY_MODE == PARITY_ODD) ? ~(^data_in) : ^data_in;
          bit_cnt_d = '0;
          tx_data_d = 1'b0;
          timer_clr = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          tx_data_d = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            if (PARITY_MODE != PARITY_NONE) begin
              state_d   = ST_PARITY;
              tx_data_d = parity_q;
            end else begin
              state_d   = ST_STOP;
              tx_data_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            shift_d   = shift_q >> 1;
            tx_data_d = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
          tx_data_d = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            tx_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        tx_data_d = 1'b1;
      end
    endcase
  end

  // State, counters, latched word and registered line; reset idles the line high.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_data_q <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_data_q <= tx_data_d;
      tx_done_q <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter_cfg.sv
// Directed bench for uart_transmitter_cfg: four instances cover the default
// configuration, even parity, odd parity and 7 data bits with 2 stop bits.
module tb_uart_transmitter_cfg;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [3:0] valid;
  logic [7:0] data_in;
  wire  [3:0] ready;
  wire  [3:0] busy;
  wire  [3:0] done;
  wire  [3:0] line;

  int n_checks;
  int n_err;
  int tcnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle tick every fourth clock, changed just after the rising edge.
  initial begin
    tick = 1'b0;
    tcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      tcnt++;
      tick = (tcnt % 4 == 0);
    end
  end

  uart_transmitter_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
    .system_clk(clk), .rst_n(rst_n), .tick_in(tick), .tx_valid(valid[0]), .data_in(data_in),
    .tx_ready(ready[0]), .tx_busy(busy[0]), .tx_done(done[0]), .tx_data(line[0]));
  uart_transmitter_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) u_dut1 (
    .system_clk(clk), .rst_n(rst_n), .tick_in(tick), .tx_valid(valid[1]), .data_in(data_in),
    .tx_ready(ready[1]), .tx_busy(busy[1]), .tx_done(done[1]), .tx_data(line[1]));
  uart_transmitter_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(1)) u_dut2 (
    .system_clk(clk), .rst_n(rst_n), .tick_in(tick), .tx_valid(valid[2]), .data_in(data_in),
    .tx_ready(ready[2]), .tx_busy(busy[2]), .tx_done(done[2]), .tx_data(line[2]));
  uart_transmitter_cfg #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(2)) u_dut3 (
    .system_clk(clk), .rst_n(rst_n), .tick_in(tick), .tx_valid(valid[3]), .data_in(data_in[6:0]),
    .tx_ready(ready[3]), .tx_busy(busy[3]), .tx_done(done[3]), .tx_data(line[3]));

  // Expected per-tick line: frame bit i (bit 0 first on the wire) held for 16 ticks.
  function automatic logic [255:0] expand(input logic [15:0] bits, input int nb);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < nb; i++)
      for (int k = 0; k < 16; k++)
        r[i*16+k] = bits[i];
    return r;
  endfunction

  // Request a frame at a falling edge; returns one falling edge after acceptance.
  task automatic launch(input int d, input logic [7:0] dat);
    @(negedge clk);
    data_in  = dat;
    valid[d] = 1'b1;
    @(negedge clk);
    valid[d] = 1'b0;
  endtask

  // Record the line on every tick cycle while busy, until tx_done is seen.
  // mode 1: pulse tx_valid with 0xFF at tick 40; mode 2: assert reset at tick 72.
  task automatic capture(input int d, input int mode, output int n, output logic [255:0] v,
                         output logic timed_out, output logic aborted);
    int poke;
    n = 0; v = '0; timed_out = 1'b1; aborted = 1'b0; poke = 0;
    for (int c = 0; c < 4000; c++) begin
      if (done[d]) begin
        timed_out = 1'b0;
        break;
      end
      if (poke == 1) begin
        valid[d] = 1'b0;
        data_in  = 8'h00;
        poke = 2;
      end
      if (busy[d] && tick) begin
        if (n < 256) v[n] = line[d];
        n++;
      end
      if (mode == 1 && n == 40 && poke == 0) begin
        valid[d] = 1'b1;
        data_in  = 8'hFF;
        poke = 1;
      end
      if (mode == 2 && n == 72) begin
        rst_n = 1'b0;
        timed_out = 1'b0;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = '0; data_in = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (line !== 4'hF) begin n_err++; $display("FAIL reset_line: got %b want 1111", line); end
    n_checks++; if (ready !== 4'hF) begin n_err++; $display("FAIL reset_ready: got %b want 1111", ready); end
    n_checks++; if (busy !== 4'h0) begin n_err++; $display("FAIL reset_busy: got %b want 0000", busy); end
    n_checks++; if (done !== 4'h0) begin n_err++; $display("FAIL reset_done: got %b want 0000", done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int n; logic [255:0] v; logic to, ab;
    launch(0, 8'hA5);
    data_in = 8'h5A;
    n_checks++; if (line[0] !== 1'b0) begin n_err++; $display("FAIL basic_start_line: got %b want 0", line[0]); end
    n_checks++; if (ready[0] !== 1'b0 || busy[0] !== 1'b1) begin n_err++; $display("FAIL basic_busy: ready=%b busy=%b want 0/1", ready[0], busy[0]); end
    capture(0, 0, n, v, to, ab);
    n_checks++; if (to !== 1'b0) begin n_err++; $display("FAIL basic_timeout: no tx_done"); end
    n_checks++; if (n != 160) begin n_err++; $display("FAIL basic_ticks: got %0d want 160", n); end
    n_checks++; if (v !== expand(16'h034A, 10)) begin n_err++; $display("FAIL basic_line: got %h want %h", v, expand(16'h034A, 10)); end
    n_checks++; if (ready[0] !== 1'b1) begin n_err++; $display("FAIL basic_done_ready: got %b want 1", ready[0]); end
    @(negedge clk);
    n_checks++; if (done[0] !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", done[0]); end
  endtask

  task automatic test_parity();
    int n; logic [255:0] v; logic to, ab;
    launch(1, 8'h07);
    capture(1, 0, n, v, to, ab);
    n_checks++; if (to !== 1'b0 || n != 176) begin n_err++; $display("FAIL even_ticks: got %0d timeout=%b want 176", n, to); end
    n_checks++; if (v[144] !== 1'b1) begin n_err++; $display("FAIL even_parity_bit: got %b want 1", v[144]); end
    n_checks++; if (v !== expand(16'h060E, 11)) begin n_err++; $display("FAIL even_line: got %h want %h", v, expand(16'h060E, 11)); end
    launch(2, 8'h07);
    capture(2, 0, n, v, to, ab);
    n_checks++; if (to !== 1'b0 || n != 176) begin n_err++; $display("FAIL odd_ticks: got %0d timeout=%b want 176", n, to); end
    n_checks++; if (v[144] !== 1'b0) begin n_err++; $display("FAIL odd_parity_bit: got %b want 0", v[144]); end
    n_checks++; if (v !== expand(16'h040E, 11)) begin n_err++; $display("FAIL odd_line: got %h want %h", v, expand(16'h040E, 11)); end
  endtask

  task automatic test_db7_sb2();
    int n; logic [255:0] v; logic to, ab;
    launch(3, 8'h7F);
    capture(3, 0, n, v, to, ab);
    n_checks++; if (to !== 1'b0 || n != 160) begin n_err++; $display("FAIL db7_ticks: got %0d timeout=%b want 160", n, to); end
    n_checks++; if (v !== expand(16'h03FE, 10)) begin n_err++; $display("FAIL db7_line: got %h want %h", v, expand(16'h03FE, 10)); end
  endtask

  task automatic test_back_to_back();
    int n; logic [255:0] v; logic to, ab;
    @(negedge clk);
    data_in  = 8'h55;
    valid[0] = 1'b1;
    @(negedge clk);
    data_in = 8'hAA;
    capture(0, 0, n, v, to, ab);
    n_checks++; if (to !== 1'b0 || n != 160) begin n_err++; $display("FAIL b2b_first_ticks: got %0d timeout=%b want 160", n, to); end
    n_checks++; if (v !== expand(16'h02AA, 10)) begin n_err++; $display("FAIL b2b_first_line: got %h want %h", v, expand(16'h02AA, 10)); end
    n_checks++; if (line[0] !== 1'b1 || ready[0] !== 1'b1) begin n_err++; $display("FAIL b2b_done_cycle: line=%b ready=%b want 1/1", line[0], ready[0]); end
    @(negedge clk);
    valid[0] = 1'b0;
    n_checks++; if (line[0] !== 1'b0 || busy[0] !== 1'b1) begin n_err++; $display("FAIL b2b_no_gap: line=%b busy=%b want 0/1", line[0], busy[0]); end
    capture(0, 0, n, v, to, ab);
    n_checks++; if (to !== 1'b0 || n != 160) begin n_err++; $display("FAIL b2b_second_ticks: got %0d timeout=%b want 160", n, to); end
    n_checks++; if (v !== expand(16'h0354, 10)) begin n_err++; $display("FAIL b2b_second_line: got %h want %h", v, expand(16'h0354, 10)); end
  endtask

  task automatic test_ignore_midframe();
    int n; logic [255:0] v; logic to, ab;
    launch(0, 8'h81);
    data_in = 8'h33;
    capture(0, 1, n, v, to, ab);
    n_checks++; if (to !== 1'b0 || n != 160) begin n_err++; $display("FAIL ignore_ticks: got %0d timeout=%b want 160", n, to); end
    n_checks++; if (v !== expand(16'h0302, 10)) begin n_err++; $display("FAIL ignore_line: got %h want %h", v, expand(16'h0302, 10)); end
    repeat (2) @(negedge clk);
    n_checks++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL ignore_no_restart: busy=%b want 0", busy[0]); end
  endtask

  task automatic test_reset_midframe();
    int n; int ndone; logic [255:0] v; logic to, ab;
    launch(0, 8'hA5);
    capture(0, 2, n, v, to, ab);
    n_checks++; if (ab !== 1'b1) begin n_err++; $display("FAIL rstmid_reached: aborted=%b want 1", ab); end
    n_checks++; if (v[71] !== 1'b0) begin n_err++; $display("FAIL rstmid_bit3_low: got %b want 0", v[71]); end
    #1;
    n_checks++; if (line[0] !== 1'b1) begin n_err++; $display("FAIL rstmid_line_async: got %b want 1", line[0]); end
    n_checks++; if (busy[0] !== 1'b0 || ready[0] !== 1'b1) begin n_err++; $display("FAIL rstmid_idle: busy=%b ready=%b want 0/1", busy[0], ready[0]); end
    ndone = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done[0]) ndone++;
    end
    n_checks++; if (ndone != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d pulses want 0", ndone); end
    launch(0, 8'h3C);
    capture(0, 0, n, v, to, ab);
    n_checks++; if (to !== 1'b0 || n != 160) begin n_err++; $display("FAIL rstmid_next_ticks: got %0d timeout=%b want 160", n, to); end
    n_checks++; if (v !== expand(16'h0278, 10)) begin n_err++; $display("FAIL rstmid_next_line: got %h want %h", v, expand(16'h0278, 10)); end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    test_reset();
    test_basic();
    test_parity();
    test_db7_sb2();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_transmitter_cfg.md
UART_TRANSMITTER_CFG -- requirements
Module: uart_transmitter_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, tick_in pulses per bit period (legal 4..64).
REQ-003 SHALL have parameter PARITY_MODE, default 0, parity mode (0 none, 1 even, 2 odd).
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-005 SHALL have port system_clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port tick_in  input  1  one-clock oversample strobe at OVERSAMPLE x baud.
REQ-008 SHALL have port tx_valid  input  1  frame request.
REQ-009 SHALL have port data_in  input  DATA_BITS  frame payload, sampled only at acceptance.
REQ-010 SHALL have port tx_ready  output  1  high only in IDLE; request accepted when tx_valid && tx_ready.
REQ-011 SHALL have port tx_busy  output  1  high from the cycle after acceptance until frame end.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse at frame completion.
REQ-013 SHALL have port tx_data  output  1  registered serial line, idle high.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY_MODE=0.
REQ-015 On acceptance SHALL latch data_in, clear tick and bit counters, drive tx_data=0 and enter START on the same edge.
REQ-016 Each bit SHALL last exactly OVERSAMPLE tick_in pulses; clock cycles without tick_in SHALL not advance counters.
REQ-017 DATA SHALL send the latched word LSB first; tx_data SHALL change only on the edge consuming a bit's final tick.
REQ-018 Parity bit SHALL be XOR of latched data (even) or its inverse (odd).
REQ-019 STOP SHALL hold tx_data=1 for STOP_BITS x OVERSAMPLE ticks, then enter IDLE.
REQ-020 Frame length SHALL be (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) x OVERSAMPLE ticks.
REQ-021 tx_done SHALL be high exactly the one cycle after the final stop tick, coincident with first tx_ready=1.
REQ-022 If tx_valid is high in that cycle, a new frame SHALL be accepted immediately (no extra idle bit).
REQ-023 tx_valid and data_in SHALL be ignored while not in IDLE; tick_in SHALL be ignored in IDLE.
REQ-024 Tick counter width SHALL be $clog2(OVERSAMPLE) (min 1); bit counter width $clog2(DATA_BITS); counters wrap only via explicit clear.
REQ-025 Illegal parameter values SHALL trigger an elaboration-time error.

Reset
REQ-026 rst_n low SHALL asynchronously force tx_data=1, tx_ready=1, tx_busy=0, tx_done=0, state IDLE, counters and shift register 0.
REQ-027 Reset mid-frame SHALL abort the frame; line high immediately; no tx_done; first acceptance after release starts a clean frame.

Structure
REQ-028 State encoding and PARITY_NONE/EVEN/ODD constants SHALL live in shared package uart_pkg.
REQ-029 Bit-period timing SHALL be a sub-module uart_bit_timer (tick counter, clear input, bit_end output).

Verification
REQ-030 Defaults, tick every 4 clocks, data 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 each 16 ticks; 160 ticks total; one tx_done.
REQ-031 PARITY_MODE=1, data 0x07 -> parity bit 1; PARITY_MODE=2, same data -> parity bit 0; frame 176 ticks.
REQ-032 DATA_BITS=7, STOP_BITS=2, data 0x7F -> start, seven 1s, stop high 32 ticks; 160 ticks total.
REQ-033 tx_valid held high with 0x55 then 0xAA -> second start bit begins the edge of the tx_done cycle; no idle gap.
REQ-034 rst_n pulsed low during data bit 3 -> tx_data=1 asynchronously, no tx_done; next frame 0x3C transmits correctly.
REQ-035 tx_valid with data_in=0xFF pulsed mid-frame, data_in changed mid-frame -> ignored; current frame unchanged.
